wishbone_ram_slave: RTL and testbench

// - Wishbone classic slave sitting directly downstream of the 64-bit wishbone master.
// - Consumes addr/we/data/cyc/stb and returns read data plus ack.
// - Backs a word-addressed RAM window for JTAG/TAP debug reads and writes.
// - Programmable wait states model slow memories, so the master's INIT_*/STOP_* phases get exercised.

---
 rtl/wishbone_ram_slave_pkg.sv | 18 +
 rtl/wishbone_ram_slave_mem.sv | 30 +++
 rtl/wishbone_ram_slave.sv | 141 ++++++++++++++
 tb/tb_wishbone_ram_slave.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/wishbone_ram_slave_pkg.sv
// rtl/wishbone_ram_slave_pkg.sv - shared widths, FSM encoding and constants for the wishbone RAM slave
package wishbone_ram_slave_pkg;

    localparam int          WB_DATA_W   = 64;
    localparam int          WB_ADDR_W   = 32;
    localparam logic [63:0] OOR_PATTERN = 64'hDEAD_BEEF_DEAD_BEEF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/wishbone_ram_slave_mem.sv
// rtl/wishbone_ram_slave_mem.sv - single-port word RAM, sync write, registered read, no reset on storage
module wishbone_ram_slave_mem
    import wishbone_ram_slave_pkg::*;
#(
    parameter int DEPTH_WORDS = 64,
    parameter int AW          = 6
) (
    input  logic                 i_clk,
    input  logic                 i_we,
    input  logic                 i_re,
    input  logic [AW-1:0]        i_addr,
    input  logic [WB_DATA_W-1:0] i_wdata,
    output logic [WB_DATA_W-1:0] o_rdata
);

    logic [WB_DATA_W-1:0] r_mem [DEPTH_WORDS];
    logic [WB_DATA_W-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/wishbone_ram_slave.sv
// rtl/wishbone_ram_slave.sv - wishbone classic slave fronting a word RAM with programmable wait states
module wishbone_ram_slave
    import wishbone_ram_slave_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
    parameter int          DEPTH_WORDS = 64,
    parameter int          WAIT_STATES = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [WB_ADDR_W-1:0] addr_i,
    input  logic                 we_i,
    input  logic [WB_DATA_W-1:0] data_i,
    input  logic                 cyc_i,
    input  logic                 stb_i,
    output logic [WB_DATA_W-1:0] data_o,
    output logic                 ack_o,
    output logic                 busy_o,
    output logic [7:0]           oor_count_o
);

    localparam int          AW        = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  WAIT_LOAD = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

    state_t               r_state, w_next;
    logic [3:0]           r_wait_cnt, w_wait_cnt_next;
    logic                 r_ack;
    logic [7:0]           r_oor_cnt;
    logic [AW-1:0]        r_idx;
    logic                 r_inrange, r_we;
    logic [WB_DATA_W-1:0] r_data;
    logic                 r_rd_valid, r_rd_oor;

    logic                 w_req;
    logic [31:0]          w_offset, w_word;
    logic                 w_live_inrange;
    logic                 w_in_idle, w_enter_ack;
    logic [AW-1:0]        w_cur_idx;
    logic                 w_cur_inrange, w_cur_we;
    logic [WB_DATA_W-1:0] w_cur_data, w_mem_rdata;
    logic                 w_mem_we, w_mem_re;

    assign w_req          = cyc_i & stb_i;
    assign w_offset       = addr_i - ADDR_BASE;
    assign w_word         = w_offset >> 3;
    assign w_live_inrange = (addr_i >= ADDR_BASE) && (w_word < 32'(DEPTH_WORDS));

    // With zero wait states IDLE goes straight to ACK, so the live bus fields must feed the RAM that cycle
    assign w_in_idle     = (r_state == ST_IDLE);
    assign w_cur_idx     = w_in_idle ? w_word[AW-1:0] : r_idx;
    assign w_cur_inrange = w_in_idle ? w_live_inrange : r_inrange;
    assign w_cur_we      = w_in_idle ? we_i : r_we;
    assign w_cur_data    = w_in_idle ? data_i : r_data;

    assign w_enter_ack = (w_next == ST_ACK) && (r_state != ST_ACK);
    assign w_mem_we    = w_enter_ack & w_cur_we & w_cur_inrange;
    assign w_mem_re    = w_enter_ack & ~w_cur_we & w_cur_inrange;

    always_comb begin
        w_next          = r_state;
        w_wait_cnt_next = r_wait_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_req) begin
                    if (WAIT_STATES == 0) begin
                        w_next = ST_ACK;
                    end else begin
                        w_next          = ST_WAIT;
                        w_wait_cnt_next = WAIT_LOAD;
                    end
                end
            end
            ST_WAIT: begin
                if (!w_req) begin
                    w_next = ST_IDLE;
                end else if (r_wait_cnt == 4'd0) begin
                    w_next = ST_ACK;
                end else begin
                    w_wait_cnt_next = r_wait_cnt - 4'd1;
                end
            end
            ST_ACK: begin
                if (!w_req) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= ST_IDLE;
            r_wait_cnt <= 4'd0;
            r_ack      <= 1'b0;
            r_oor_cnt  <= 8'd0;
            r_idx      <= '0;
            r_inrange  <= 1'b0;
            r_we       <= 1'b0;
            r_data     <= '0;
            r_rd_valid <= 1'b0;
            r_rd_oor   <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_wait_cnt <= w_wait_cnt_next;
            r_ack      <= (w_next == ST_ACK);
            if (w_in_idle && w_req) begin
                r_idx     <= w_word[AW-1:0];
                r_inrange <= w_live_inrange;
                r_we      <= we_i;
                r_data    <= data_i;
            end
            if (w_enter_ack && !w_cur_inrange) begin
                r_oor_cnt <= sat_inc8(r_oor_cnt);
            end
            if (w_enter_ack && !w_cur_we) begin
                r_rd_valid <= 1'b1;
                r_rd_oor   <= ~w_cur_inrange;
            end
        end
    end

    wishbone_ram_slave_mem #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_mem (
        .i_clk   (clk_i),
        .i_we    (w_mem_we),
        .i_re    (w_mem_re),
        .i_addr  (w_cur_idx),
        .i_wdata (w_cur_data),
        .o_rdata (w_mem_rdata)
    );

    // Read data lives in the RAM output register; it only moves on a completed in-range read
    assign data_o      = !r_rd_valid ? '0 : (r_rd_oor ? OOR_PATTERN : w_mem_rdata);
    assign ack_o       = r_ack;
    assign busy_o      = (r_state == ST_WAIT) || (r_state == ST_ACK);
    assign oor_count_o = r_oor_cnt;

endmodule

// File: tb/tb_wishbone_ram_slave.sv
// tb/tb_wishbone_ram_slave.sv - directed scoreboard bench for wishbone_ram_slave
module tb_wishbone_ram_slave;

    localparam int          WS    = 2;
    localparam int          DEPTH = 64;
    localparam logic [63:0] DEAD  = 64'hDEAD_BEEF_DEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] addr = '0;
    logic        we = 1'b0;
    logic [63:0] wdata = '0;
    logic        cyc = 1'b0;
    logic        stb = 1'b0;
    logic [63:0] rdata;
    logic        ack;
    logic        busy;
    logic [7:0]  oor;

    int n_cmp = 0;
    int n_fail = 0;
    int n_strobe = 0;
    int oor_exp = 0;

    logic [63:0] model [DEPTH];
    logic [63:0] exp_q [$];

    wishbone_ram_slave #(
        .ADDR_BASE   (32'h0000_0000),
        .DEPTH_WORDS (DEPTH),
        .WAIT_STATES (WS)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .addr_i      (addr),
        .we_i        (we),
        .data_i      (wdata),
        .cyc_i       (cyc),
        .stb_i       (stb),
        .data_o      (rdata),
        .ack_o       (ack),
        .busy_o      (busy),
        .oor_count_o (oor)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (dut.w_mem_we) n_strobe++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit in_range(input logic [31:0] a);
        return a < 32'(DEPTH * 8);
    endfunction

    task automatic xfer(input string tag, input logic [31:0] a, input logic w,
                        input logic [63:0] d, input int hold);
        int          lat;
        bit          got;
        logic [63:0] exp_d;
        if (!w) exp_q.push_back(in_range(a) ? model[a[8:3]] : DEAD);
        addr = a; we = w; wdata = d; cyc = 1'b1; stb = 1'b1;
        lat = 0; got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(posedge clk); #1;
            lat++;
            if (i == 0) begin
                addr = $urandom; we = ~w; wdata = {$urandom, $urandom};
            end
            if (ack) got = 1;
        end
        check({tag, " ack_seen"}, 64'(got), 64'd1);
        if (got) begin
            check({tag, " latency"}, 64'(lat), 64'(1 + WS));
            check({tag, " busy_in_ack"}, 64'(busy), 64'd1);
            if (!in_range(a)) oor_exp = (oor_exp == 255) ? 255 : oor_exp + 1;
            check({tag, " oor_count"}, 64'(oor), 64'(oor_exp));
            if (!w) begin
                exp_d = exp_q.pop_front();
                check({tag, " rdata"}, rdata, exp_d);
            end else if (in_range(a)) begin
                model[a[8:3]] = d;
            end
            for (int i = 0; i < hold; i++) begin
                @(posedge clk); #1;
                check({tag, " ack_held"}, 64'(ack), 64'd1);
            end
        end else if (!w) begin
            void'(exp_q.pop_front());
        end
        cyc = 1'b0; stb = 1'b0;
        @(posedge clk); #1;
        check({tag, " ack_drop"}, 64'(ack), 64'd0);
        check({tag, " busy_drop"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int          s0;
        logic [63:0] held;

        repeat (2) @(posedge clk);
        #1;
        check("rst ack", 64'(ack), 64'd0);
        check("rst busy", 64'(busy), 64'd0);
        check("rst data", rdata, 64'd0);
        check("rst oor", 64'(oor), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        xfer("wr10", 32'h10, 1'b1, 64'h0123_4567_89AB_CDEF, 3);
        xfer("rd10", 32'h10, 1'b0, 64'h0, 0);
        held = 64'h0123_4567_89AB_CDEF;
        repeat (3) @(posedge clk);
        #1;
        check("rd10 data_hold", rdata, held);
        xfer("wr08", 32'h08, 1'b1, 64'hAAAA_5555_AAAA_5555, 0);
        check("wr08 data_unchanged", rdata, held);

        s0 = n_strobe;
        xfer("wr18a", 32'h18, 1'b1, 64'h1, 10);
        xfer("wr18b", 32'h18, 1'b1, 64'h2, 0);
        check("wr18 strobes", 64'(n_strobe - s0), 64'd2);
        xfer("rd18", 32'h18, 1'b0, 64'h0, 0);
        xfer("rd08", 32'h08, 1'b0, 64'h0, 1);

        xfer("rd200", 32'h200, 1'b0, 64'h0, 0);
        s0 = n_strobe;
        xfer("wr_below", 32'hFFFF_FFF8, 1'b1, 64'h5, 0);
        check("wr_below strobes", 64'(n_strobe - s0), 64'd0);
        xfer("rd1f8", 32'h1F8 + 32'h5, 1'b1, 64'h77, 0);
        xfer("rd1f8_back", 32'h1F8, 1'b0, 64'h0, 0);

        xfer("wr20", 32'h20, 1'b1, 64'hCAFE_F00D_0000_1234, 0);
        addr = 32'h20; we = 1'b1; wdata = 64'hBAD0_BAD0_BAD0_BAD0; cyc = 1'b1; stb = 1'b1;
        @(posedge clk); #1;
        check("abort busy", 64'(busy), 64'd1);
        cyc = 1'b0; stb = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("abort no_ack", 64'(ack), 64'd0);
        end
        xfer("rd20", 32'h20, 1'b0, 64'h0, 0);

        addr = 32'h10; we = 1'b0; cyc = 1'b1; stb = 1'b1;
        repeat (1 + WS) @(posedge clk);
        #1;
        check("rstack ack_before", 64'(ack), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("rstack ack_async", 64'(ack), 64'd0);
        check("rstack busy", 64'(busy), 64'd0);
        check("rstack oor", 64'(oor), 64'd0);
        check("rstack data", rdata, 64'd0);
        oor_exp = 0;
        cyc = 1'b0; stb = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        xfer("rd10_after_rst", 32'h10, 1'b0, 64'h0, 0);

        for (int i = 0; i < 256; i++) begin
            xfer("oor_sat", 32'h0000_1000 + 32'(i * 8), 1'b0, 64'h0, 0);
        end
        check("oor saturated", 64'(oor), 64'hFF);
        check("scoreboard empty", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
